// File: rtl/branch_resolve.sv
// Branch/jump resolution for the ID stage: turns comparator flags into a registered
// PC redirect held until fetch accepts it, a JAL/JALR link write and branch statistics.
module branch_resolve #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic [3:0]       br_type,
  input  logic             equal,
  input  logic             less,
  input  logic             greater,
  input  logic [31:0]      pc_id,
  input  logic [15:0]      imm16,
  input  logic [25:0]      instr_index,
  input  logic [31:0]      rs_value,
  input  logic [4:0]       rd_id,
  input  logic             stall_id,
  input  logic             flush,
  input  logic             fetch_ready,
  output logic             cmp_with_zero,
  output logic             br_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             link_valid,
  output logic [4:0]       link_addr,
  output logic [31:0]      link_pc,
  output logic             illegal_type,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  // state | meaning
  // IDLE  | no redirect pending; a branch may be accepted
  // REDIR | redirect_pc offered to fetch, waiting for fetch_ready
  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } state_t;

  localparam logic [3:0] T_NONE = 4'd0;
  localparam logic [3:0] T_BEQ  = 4'd1;
  localparam logic [3:0] T_BNE  = 4'd2;
  localparam logic [3:0] T_BLEZ = 4'd3;
  localparam logic [3:0] T_BGTZ = 4'd4;
  localparam logic [3:0] T_BLTZ = 4'd5;
  localparam logic [3:0] T_BGEZ = 4'd6;
  localparam logic [3:0] T_J    = 4'd7;
  localparam logic [3:0] T_JAL  = 4'd8;
  localparam logic [3:0] T_JR   = 4'd9;
  localparam logic [3:0] T_JALR = 4'd10;

  state_t      state_q, state_d;
  logic        accept;
  logic        taken;
  logic        is_link;
  logic        is_counted;
  logic        is_illegal;
  logic [4:0]  link_dest;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] target;

  assign cmp_with_zero = (br_type >= T_BLEZ) && (br_type <= T_BGEZ);

  assign pc_plus4  = pc_id + 32'd4;
  assign br_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_target  = {pc_plus4[31:28], instr_index, 2'b00};

  // Type decode; NONE and illegal types are never taken and never counted.
  always_comb begin
    taken      = 1'b0;
    target     = br_target;
    is_link    = 1'b0;
    is_counted = 1'b1;
    is_illegal = 1'b0;
    link_dest  = 5'd31;
    case (br_type)
      T_NONE: is_counted = 1'b0;
      T_BEQ:  taken = equal;
      T_BNE:  taken = ~equal;
      T_BLEZ: taken = less | equal;
      T_BGTZ: taken = greater;
      T_BLTZ: taken = less;
      T_BGEZ: taken = greater | equal;
      T_J: begin
        taken  = 1'b1;
        target = j_target;
      end
      T_JAL: begin
        taken   = 1'b1;
        target  = j_target;
        is_link = 1'b1;
      end
      T_JR: begin
        taken  = 1'b1;
        target = rs_value;
      end
      T_JALR: begin
        taken     = 1'b1;
        target    = rs_value;
        is_link   = 1'b1;
        link_dest = rd_id;
      end
      default: begin
        is_counted = 1'b0;
        is_illegal = 1'b1;
      end
    endcase
  end

  // flush gates accept, so a flushed cycle leaves no link, count or illegal pulse
  assign accept = br_valid & ~stall_id & br_ready & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && taken) state_d = REDIR;
      REDIR:   if (fetch_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    br_ready       = 1'b0;
    redirect_valid = 1'b0;
    case (state_q)
      IDLE:    br_ready = 1'b1;
      REDIR:   redirect_valid = 1'b1;
      default: br_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_pc  <= 32'd0;
      link_valid   <= 1'b0;
      link_addr    <= 5'd0;
      link_pc      <= 32'd0;
      illegal_type <= 1'b0;
    end else begin
      link_valid   <= accept & is_link;
      illegal_type <= accept & is_illegal;
      if (accept && taken) begin
        redirect_pc <= target;
      end
      if (accept && is_link) begin
        link_addr <= link_dest;
        link_pc   <= pc_id + 32'd8;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else begin
      if (accept && is_counted) br_cnt <= br_cnt + CNT_W'(1);
      if (accept && taken) taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: a vector table for type decode/targets plus
// hand sequences for back-pressure, stall, flush, async reset and counter wrap.
module tb_branch_resolve;
  localparam int CNT_W = 8;
  localparam int NV = 18;

  logic             clk = 1'b0;
  logic             reset;
  logic             br_valid;
  logic [3:0]       br_type;
  logic             equal, less, greater;
  logic [31:0]      pc_id;
  logic [15:0]      imm16;
  logic [25:0]      instr_index;
  logic [31:0]      rs_value;
  logic [4:0]       rd_id;
  logic             stall_id, flush, fetch_ready;
  logic             cmp_with_zero, br_ready, redirect_valid;
  logic [31:0]      redirect_pc;
  logic             link_valid;
  logic [4:0]       link_addr;
  logic [31:0]      link_pc;
  logic             illegal_type;
  logic [CNT_W-1:0] br_cnt, taken_cnt;

  branch_resolve #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_type(br_type),
    .equal(equal), .less(less), .greater(greater), .pc_id(pc_id), .imm16(imm16),
    .instr_index(instr_index), .rs_value(rs_value), .rd_id(rd_id),
    .stall_id(stall_id), .flush(flush), .fetch_ready(fetch_ready),
    .cmp_with_zero(cmp_with_zero), .br_ready(br_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .link_valid(link_valid), .link_addr(link_addr), .link_pc(link_pc),
    .illegal_type(illegal_type), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  typ;
    logic        eq, lt, gt;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
    logic [4:0]  rd;
    logic        taken;
    logic [31:0] tgt;
    logic        link;
    logic [4:0]  laddr;
    logic [31:0] lpc;
    logic        ill;
  } vec_t;

  vec_t vecs[NV];
  int n_tests = 0;
  int n_fail  = 0;
  logic [CNT_W-1:0] exp_br, exp_tk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, " br_cnt"}, 32'(br_cnt), 32'(exp_br));
    chk({tag, " taken_cnt"}, 32'(taken_cnt), 32'(exp_tk));
  endtask

  task automatic idle_inputs();
    br_valid = 1'b0; br_type = 4'd0; equal = 1'b0; less = 1'b0; greater = 1'b0;
    pc_id = 32'd0; imm16 = 16'd0; instr_index = 26'd0; rs_value = 32'd0; rd_id = 5'd0;
    stall_id = 1'b0; flush = 1'b0; fetch_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          typ   eq    lt    gt    pc             imm       idx          rs             rd    tk    tgt            lk    la     lpc           ill
    vecs[0]  = '{4'd1, 1'b1, 1'b0, 1'b0, 32'h0000_3000, 16'h0004, 26'h0,       32'h0,         5'd0, 1'b1, 32'h0000_3014, 1'b0, 5'd0,  32'h0,        1'b0};
    vecs[1]  = '{4'd6, 1'b0, 1'b1, 1'b0, 32'h0000_3000, 16'hFFFF, 26'h0,       32'h0,         5'd0, 1'b0, 32'h0,         1'b0, 5'd0,  32'h0,        1'b0};
    vecs[2]  = '{4'd6, 1'b1, 1'b0, 1'b0, 32'h0000_3000, 16'hFFFF, 26'h0,       32'h0,         5'd0, 1'b1, 32'h0000_3000, 1'b0, 5'd0,  32'h0,        1'b0};
    vecs[3]  = '{4'd2, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 16'h8000, 26'h0,       32'h0,         5'd0, 1'b0, 32'h0,         1'b0, 5'd0,  32'h0,        1'b0};
    vecs[4]  = '{4'd2, 1'b0, 1'b1, 1'b0, 32'h0000_1000, 16'h8000, 26'h0,       32'h0,         5'd0, 1'b1, 32'hFFFE_1004, 1'b0, 5'd0,  32'h0,        1'b0};
    vecs[5]  = '{4'd3, 1'b0, 1'b1, 1'b0, 32'h0000_2000, 16'h0001, 26'h0,       32'h0,         5'd0, 1'b1, 32'h0000_2008, 1'b0, 5'd0,  32'h0,        1'b0};
    vecs[6]  = '{4'd3, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 16'h0001, 26'h0,       32'h0,         5'd0, 1'b0, 32'h0,         1'b0, 5'd0,  32'h0,        1'b0};
    vecs[7]  = '{4'd4, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 16'h0002, 26'h0,       32'h0,         5'd0, 1'b1, 32'h0000_200C, 1'b0, 5'd0,  32'h0,        1'b0};
    vecs[8]  = '{4'd5, 1'b1, 1'b0, 1'b0, 32'h0000_4000, 16'h0010, 26'h0,       32'h0,         5'd0, 1'b0, 32'h0,         1'b0, 5'd0,  32'h0,        1'b0};
    vecs[9]  = '{4'd5, 1'b0, 1'b1, 1'b0, 32'h0000_4000, 16'h0010, 26'h0,       32'h0,         5'd0, 1'b1, 32'h0000_4044, 1'b0, 5'd0,  32'h0,        1'b0};
    vecs[10] = '{4'd7, 1'b0, 1'b0, 1'b0, 32'hF000_0000, 16'h0000, 26'h3FFFFFF, 32'h0,         5'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 5'd0,  32'h0,        1'b0};
    vecs[11] = '{4'd7, 1'b0, 1'b0, 1'b0, 32'h0FFF_FFFC, 16'h0000, 26'h0,       32'h0,         5'd0, 1'b1, 32'h1000_0000, 1'b0, 5'd0,  32'h0,        1'b0};
    vecs[12] = '{4'd8, 1'b0, 1'b0, 1'b0, 32'h0000_3008, 16'h0000, 26'h0000C10, 32'h0,         5'd0, 1'b1, 32'h0000_3040, 1'b1, 5'd31, 32'h0000_3010, 1'b0};
    vecs[13] = '{4'd9, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 16'h0000, 26'h0,       32'h0000_4001, 5'd0, 1'b1, 32'h0000_4001, 1'b0, 5'd0,  32'h0,        1'b0};
    vecs[14] = '{4'd10,1'b0, 1'b0, 1'b0, 32'h0000_0100, 16'h0000, 26'h0,       32'h8000_0000, 5'd5, 1'b1, 32'h8000_0000, 1'b1, 5'd5,  32'h0000_0108, 1'b0};
    vecs[15] = '{4'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 16'h0004, 26'h0,       32'h0,         5'd0, 1'b0, 32'h0,         1'b0, 5'd0,  32'h0,        1'b0};
    vecs[16] = '{4'd13,1'b1, 1'b0, 1'b0, 32'h0000_0100, 16'h0004, 26'h0,       32'h0,         5'd0, 1'b0, 32'h0,         1'b0, 5'd0,  32'h0,        1'b1};
    vecs[17] = '{4'd1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 16'h0000, 26'h0,       32'h0,         5'd0, 1'b1, 32'h0000_0000, 1'b0, 5'd0,  32'h0,        1'b0};

    idle_inputs();
    reset = 1'b1;
    exp_br = '0;
    exp_tk = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst redirect_pc", redirect_pc, 32'd0);
    chk("rst link_valid", 32'(link_valid), 32'd0);
    chk("rst link_pc", link_pc, 32'd0);
    chk("rst link_addr", 32'(link_addr), 32'd0);
    chk("rst illegal_type", 32'(illegal_type), 32'd0);
    chk("rst br_ready", 32'(br_ready), 32'd1);
    chk_counts("rst");
    reset = 1'b0;

    // table: one accepted instruction per entry, fetch_ready held high
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      br_type = vecs[i].typ; equal = vecs[i].eq; less = vecs[i].lt; greater = vecs[i].gt;
      pc_id = vecs[i].pc; imm16 = vecs[i].imm; instr_index = vecs[i].idx;
      rs_value = vecs[i].rs; rd_id = vecs[i].rd; br_valid = 1'b1; fetch_ready = 1'b1;
      #1;
      chk($sformatf("v%0d cmp_with_zero", i), 32'(cmp_with_zero),
          32'(vecs[i].typ >= 4'd3 && vecs[i].typ <= 4'd6));
      chk($sformatf("v%0d br_ready", i), 32'(br_ready), 32'd1);
      @(negedge clk);
      br_valid = 1'b0;
      if (vecs[i].typ >= 4'd1 && vecs[i].typ <= 4'd10) exp_br++;
      if (vecs[i].taken) exp_tk++;
      chk($sformatf("v%0d redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].taken));
      if (vecs[i].taken) chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].tgt);
      chk($sformatf("v%0d link_valid", i), 32'(link_valid), 32'(vecs[i].link));
      if (vecs[i].link) begin
        chk($sformatf("v%0d link_addr", i), 32'(link_addr), 32'(vecs[i].laddr));
        chk($sformatf("v%0d link_pc", i), link_pc, vecs[i].lpc);
      end
      chk($sformatf("v%0d illegal_type", i), 32'(illegal_type), 32'(vecs[i].ill));
      chk_counts($sformatf("v%0d", i));
      @(negedge clk);
      chk($sformatf("v%0d after redirect_valid", i), 32'(redirect_valid), 32'd0);
      chk($sformatf("v%0d after br_ready", i), 32'(br_ready), 32'd1);
      chk($sformatf("v%0d after link_valid", i), 32'(link_valid), 32'd0);
      chk($sformatf("v%0d after illegal_type", i), 32'(illegal_type), 32'd0);
    end

    // JAL held in REDIR by fetch back-pressure; a BEQ offered meanwhile waits
    @(negedge clk);
    idle_inputs();
    br_type = 4'd8; pc_id = 32'h0000_3008; instr_index = 26'h0000C10;
    br_valid = 1'b1; fetch_ready = 1'b0;
    @(negedge clk);
    exp_br++; exp_tk++;
    br_type = 4'd1; equal = 1'b1; pc_id = 32'h0000_5000; imm16 = 16'h0001;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("hold%0d redirect_valid", c), 32'(redirect_valid), 32'd1);
      chk($sformatf("hold%0d redirect_pc", c), redirect_pc, 32'h0000_3040);
      chk($sformatf("hold%0d br_ready", c), 32'(br_ready), 32'd0);
      chk($sformatf("hold%0d link_valid", c), 32'(link_valid), 32'(c == 0));
      if (c == 0) begin
        chk("hold link_addr", 32'(link_addr), 32'd31);
        chk("hold link_pc", link_pc, 32'h0000_3010);
      end
      chk_counts($sformatf("hold%0d", c));
      if (c == 2) fetch_ready = 1'b1;
    end
    @(negedge clk);
    chk("handshake redirect_valid", 32'(redirect_valid), 32'd0);
    chk("handshake br_ready", 32'(br_ready), 32'd1);
    chk_counts("handshake");
    @(negedge clk);
    exp_br++; exp_tk++;
    chk("next accept redirect_valid", 32'(redirect_valid), 32'd1);
    chk("next accept redirect_pc", redirect_pc, 32'h0000_5008);
    chk_counts("next accept");
    br_valid = 1'b0;
    @(negedge clk);
    chk("next accept done", 32'(redirect_valid), 32'd0);

    // JR under stall: only the unstalled cycle's operands count
    idle_inputs();
    br_type = 4'd9; rs_value = 32'h0000_1111; br_valid = 1'b1; stall_id = 1'b1;
    @(negedge clk);
    chk("stall1 redirect_valid", 32'(redirect_valid), 32'd0);
    chk_counts("stall1");
    rs_value = 32'h0000_2222;
    @(negedge clk);
    chk("stall2 redirect_valid", 32'(redirect_valid), 32'd0);
    chk_counts("stall2");
    rs_value = 32'h0000_4000; stall_id = 1'b0;
    @(negedge clk);
    exp_br++; exp_tk++;
    chk("jr redirect_valid", 32'(redirect_valid), 32'd1);
    chk("jr redirect_pc", redirect_pc, 32'h0000_4000);
    chk_counts("jr");
    br_valid = 1'b0;
    @(negedge clk);

    // flush while REDIR is waiting on fetch
    idle_inputs();
    br_type = 4'd7; instr_index = 26'h100; br_valid = 1'b1; fetch_ready = 1'b0;
    @(negedge clk);
    exp_br++; exp_tk++;
    chk("flush redir pre", 32'(redirect_valid), 32'd1);
    br_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush redir redirect_valid", 32'(redirect_valid), 32'd0);
    chk("flush redir br_ready", 32'(br_ready), 32'd1);
    flush = 1'b0; fetch_ready = 1'b1;

    // flush on the same cycle as a JALR accept suppresses it entirely
    br_type = 4'd10; rs_value = 32'h0000_9000; rd_id = 5'd7; pc_id = 32'h0000_0200;
    br_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush jalr redirect_valid", 32'(redirect_valid), 32'd0);
    chk("flush jalr link_valid", 32'(link_valid), 32'd0);
    chk_counts("flush jalr");
    br_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush jalr late link_valid", 32'(link_valid), 32'd0);

    // flush the cycle after a JAL accept: the scheduled link still fires
    br_type = 4'd8; pc_id = 32'h0000_0400; instr_index = 26'h10; br_valid = 1'b1;
    @(negedge clk);
    exp_br++; exp_tk++;
    br_valid = 1'b0; flush = 1'b1;
    chk("flush link link_valid", 32'(link_valid), 32'd1);
    chk("flush link link_pc", link_pc, 32'h0000_0408);
    chk("flush link link_addr", 32'(link_addr), 32'd31);
    @(negedge clk);
    chk("flush link redirect_valid", 32'(redirect_valid), 32'd0);
    chk("flush link link_valid off", 32'(link_valid), 32'd0);
    chk_counts("flush link");
    flush = 1'b0;

    // asynchronous reset in the middle of REDIR
    idle_inputs();
    br_type = 4'd8; pc_id = 32'h0000_3008; instr_index = 26'h0000C10;
    br_valid = 1'b1; fetch_ready = 1'b0;
    @(negedge clk);
    br_valid = 1'b0;
    chk("pre-reset redirect_valid", 32'(redirect_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    exp_br = '0; exp_tk = '0;
    chk("async redirect_valid", 32'(redirect_valid), 32'd0);
    chk("async redirect_pc", redirect_pc, 32'd0);
    chk("async link_valid", 32'(link_valid), 32'd0);
    chk("async link_pc", link_pc, 32'd0);
    chk("async link_addr", 32'(link_addr), 32'd0);
    chk("async br_ready", 32'(br_ready), 32'd1);
    chk_counts("async");
    @(negedge clk);
    reset = 1'b0;
    fetch_ready = 1'b1;

    // 2^CNT_W taken branches, one accept every two cycles, wrap both counters
    idle_inputs();
    br_type = 4'd1; equal = 1'b1; br_valid = 1'b1;
    for (int c = 1; c <= 2 * (1 << CNT_W); c++) begin
      @(negedge clk);
      if (c == 2 * (1 << CNT_W) - 2) begin
        chk("wrap-1 br_cnt", 32'(br_cnt), (1 << CNT_W) - 1);
        chk("wrap-1 taken_cnt", 32'(taken_cnt), (1 << CNT_W) - 1);
      end
    end
    br_valid = 1'b0;
    chk("wrap br_cnt", 32'(br_cnt), 32'd0);
    chk("wrap taken_cnt", 32'(taken_cnt), 32'd0);
    chk("wrap redirect_valid", 32'(redirect_valid), 32'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Consumer of the ID-stage comparator flags (equal/less/greater). Turns them into a registered PC redirect for the fetch stage and a link write for JAL/JALR.
- Drives the comparator's compare-with-zero select from the decoded branch type.
- Holds a pending redirect until fetch accepts it.
- Keeps branch/taken statistics counters.
- Sits between the ID-stage decoder/comparator and the IF-stage PC mux of the pipelined MIPS core.

Parameters:
- CNT_W, 16, width of the branch and taken statistics counters (wrap-around).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- br_valid  in  1  ID holds a control-transfer instruction this cycle
- br_type  in  4  0 NONE, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 J, 8 JAL, 9 JR, 10 JALR; 11-15 illegal
- equal  in  1  comparator flag, same cycle as br_valid
- less  in  1  comparator flag (signed)
- greater  in  1  comparator flag (signed)
- pc_id  in  32  PC of the branch instruction
- imm16  in  16  branch offset field
- instr_index  in  26  J/JAL index field
- rs_value  in  32  forwarded rs for JR/JALR
- rd_id  in  5  rd field for JALR
- stall_id  in  1  hazard stall; ID operands not valid
- flush  in  1  exception/eret flush, synchronous
- fetch_ready  in  1  IF accepts redirect this cycle
- cmp_with_zero  out  1  comparator mode select; combinational, 1 iff br_type in 3..6
- br_ready  out  1  block can accept a branch (state IDLE)
- redirect_valid  out  1  redirect pending
- redirect_pc  out  32  redirect target, stable while redirect_valid
- link_valid  out  1  one-cycle link write pulse
- link_addr  out  5  31 for JAL, rd_id for JALR
- link_pc  out  32  pc_id+8 of the accepted instruction
- illegal_type  out  1  one-cycle pulse: accepted br_type 11-15
- br_cnt  out  CNT_W  accepted non-NONE branches/jumps
- taken_cnt  out  CNT_W  accepted taken ones

Behaviour:
- Reset (async, active-high) values:
  - state IDLE
  - redirect_valid, link_valid, illegal_type = 0
  - redirect_pc, link_pc, link_addr = 0
  - br_cnt, taken_cnt = 0
- Accept condition: accept = br_valid & ~stall_id & br_ready & ~flush.
- Taken decode, evaluated at accept on the current-cycle flags:
  - BEQ: equal
  - BNE: ~equal
  - BLEZ: less|equal
  - BGTZ: greater
  - BLTZ: less
  - BGEZ: greater|equal
  - J, JAL, JR, JALR: always taken
  - NONE and illegal: never taken
- Targets (32-bit wrap arithmetic):
  - conditional branches: pc_id + 4 + (sign_extend(imm16) << 2)
  - J/JAL: {(pc_id+4)[31:28], instr_index, 2'b00}
  - JR/JALR: rs_value, used unmodified with no alignment check
- State machine, IDLE / REDIR:
  - IDLE, accept & taken: next cycle REDIR, redirect_valid=1, redirect_pc=target. Latency exactly 1 cycle.
  - IDLE, accept & not taken: stay IDLE, no redirect; fetch continues sequentially and the delay slot is handled upstream.
  - REDIR: br_ready=0; redirect_valid and redirect_pc held stable. On a cycle with fetch_ready=1 the handshake completes and the next state is IDLE with redirect_valid=0.
  - A branch cannot be accepted in the same cycle the handshake completes. The earliest new accept is the cycle after.
- Link:
  - For an accepted JAL/JALR, link_valid pulses 1 cycle after accept with link_pc = pc_id+8 and link_addr as above.
  - The pulse is independent of fetch_ready.
- Counters:
  - br_cnt increments on accept with br_type 1-10.
  - taken_cnt increments on accept & taken.
  - Both wrap modulo 2^CNT_W.
  - Not cleared by flush.
- Flush has priority over everything:
  - The next state is IDLE with redirect_valid=0.
  - Any accept in that cycle is suppressed: no link, no count, no illegal pulse.
  - A link pulse already scheduled from the previous cycle's accept still fires.
- Illegal type: illegal_type pulses 1 cycle after accept; treated as NONE otherwise.
- stall_id=1 suppresses accept. Inputs may change while stalled; only the values on the accepting cycle matter.
- Reset mid-REDIR: the pending redirect is dropped immediately (asynchronous).

Test Plan:
1. BEQ, pc_id=0x00003000, imm16=0x0004, equal=1, fetch_ready=1 -> next cycle redirect_valid=1, redirect_pc=0x00003014; IDLE the cycle after; br_cnt=1, taken_cnt=1.
2. BGEZ with imm16=0xFFFF: cmp_with_zero=1 combinationally. less=1 -> no redirect, br_cnt=1, taken_cnt=0. Repeat with equal=1 -> redirect_pc=pc_id (pc_id+4-4).
3. JAL, pc_id=0x00003008, instr_index=0x0000C10, fetch_ready held 0 for 3 cycles:
   - redirect_valid stays 1 with redirect_pc=0x00003040 and br_ready=0 for 3 cycles.
   - link_valid pulses once with link_addr=31, link_pc=0x00003010.
   - br_valid offered during REDIR is not accepted.
4. JR with rs_value=0x00004000 while stall_id=1 for 2 cycles -> no action. Accept on the third cycle -> redirect_pc=0x00004000 one cycle later.
5. Flush asserted while in REDIR, and separately on the same cycle as a JALR accept -> redirect_valid=0 next cycle; the suppressed JALR produces no link_valid and no count.
6. Async reset mid-REDIR -> all outputs 0 immediately. Separately: 2^CNT_W taken branches -> both counters wrap to 0. br_type=13 accepted -> illegal_type pulse, no redirect, no count.
